// File: rtl/servo_ramp_pkg.sv
// Shared constants for the Wishbone servo ramp block: channel/width defaults,
// register word indices and the sweep FSM state encoding.
package servo_ramp_pkg;

    localparam int NUM_CH_DEFAULT       = 8;
    localparam int DUTY_W_DEFAULT       = 16;
    localparam int MIN_PRESCALE_DEFAULT = 16;

    localparam logic [4:0] REG_TARGET0  = 5'd0;
    localparam logic [4:0] REG_STEP     = 5'd8;
    localparam logic [4:0] REG_PRESCALE = 5'd9;
    localparam logic [4:0] REG_STATUS   = 5'd10;
    localparam logic [4:0] REG_CUR0     = 5'd16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

endpackage

// File: rtl/servo_ramp_step.sv
// Combinational saturating step: moves cur toward tgt by at most step, never
// overshooting or wrapping. A zero step means jump straight to the target.
module servo_ramp_step
    import servo_ramp_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEFAULT
) (
    input  logic [DUTY_W-1:0] i_cur,
    input  logic [DUTY_W-1:0] i_tgt,
    input  logic [DUTY_W-1:0] i_step,
    output logic [DUTY_W-1:0] o_next
);

    logic [DUTY_W:0] w_cur_x;
    logic [DUTY_W:0] w_tgt_x;
    logic [DUTY_W:0] w_up;
    logic [DUTY_W:0] w_floor;

    // One extra bit of headroom so the sum and the target+step bound cannot wrap.
    assign w_cur_x = {1'b0, i_cur};
    assign w_tgt_x = {1'b0, i_tgt};
    assign w_up    = w_cur_x + {1'b0, i_step};
    assign w_floor = w_tgt_x + {1'b0, i_step};

    always_comb begin
        o_next = i_cur;
        if (i_step == '0) begin
            o_next = i_tgt;
        end else if (i_cur < i_tgt) begin
            o_next = (w_up >= w_tgt_x) ? i_tgt : w_up[DUTY_W-1:0];
        end else if (i_cur > i_tgt) begin
            o_next = (w_cur_x <= w_floor) ? i_tgt : (i_cur - i_step);
        end
    end

endmodule

// File: rtl/wb_servo_ramp.sv
// Wishbone slave that slew-limits per-channel PWM duty toward firmware targets.
// Define WB_SERVO_RAMP_IRQ_EN to build the ramp-complete interrupt.
module wb_servo_ramp
    import servo_ramp_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEFAULT,
    parameter int DUTY_W       = DUTY_W_DEFAULT,
    parameter int MIN_PRESCALE = MIN_PRESCALE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    output logic [31:0]              wb_dat_o,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic [3:0]               wb_sel_i,
    output logic                     wb_ack_o,
    output logic [NUM_CH*DUTY_W-1:0] duty_o,
    output logic                     duty_load_o,
    output logic                     irq_o
);

    localparam int                 CH_W        = $clog2(NUM_CH);
    localparam int                 PRESC_W     = 16;
    localparam logic [CH_W-1:0]    LAST_CH     = CH_W'(NUM_CH - 1);
    localparam logic [4:0]         TGT_LAST    = REG_TARGET0 + 5'(NUM_CH - 1);
    localparam logic [4:0]         CUR_LAST    = REG_CUR0 + 5'(NUM_CH - 1);
    localparam logic [PRESC_W-1:0] PRESC_FLOOR = PRESC_W'(MIN_PRESCALE);

    logic [DUTY_W-1:0]        r_tgt [NUM_CH];
    logic [DUTY_W-1:0]        r_cur [NUM_CH];
    logic [DUTY_W-1:0]        r_step;
    logic [PRESC_W-1:0]       r_presc;
    logic [PRESC_W-1:0]       r_cnt;
    logic [1:0]               r_state;
    logic [CH_W-1:0]          r_ch;
    logic                     r_ack;
    logic [31:0]              r_dat;
    logic [NUM_CH*DUTY_W-1:0] r_duty;
    logic                     r_load;

    logic [4:0]               w_idx;
    logic                     w_req;
    logic                     w_wr;
    logic                     w_tick;
    logic                     w_last;
    logic [PRESC_W-1:0]       w_term;
    logic [NUM_CH-1:0]        w_status;
    logic [31:0]              w_status_word;
    logic [31:0]              w_rdata;
    logic [DUTY_W-1:0]        w_next;
    logic [NUM_CH*DUTY_W-1:0] w_snap;
    logic                     w_irq;
    logic                     w_unused;

    assign w_idx    = wb_adr_i[6:2];
    assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr     = w_req & wb_we_i & (wb_sel_i == 4'hF);
    assign w_term   = (r_presc < PRESC_FLOOR) ? PRESC_FLOOR : r_presc;
    assign w_tick   = (r_cnt == w_term);
    assign w_last   = (r_state == ST_SWEEP) && (r_ch == LAST_CH);
    assign w_unused = ^{wb_adr_i[31:7], wb_adr_i[1:0], wb_dat_i[31:DUTY_W]};

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_status[i] = (r_cur[i] != r_tgt[i]);
        end
    end

    assign w_status_word = {w_irq, {(31 - NUM_CH){1'b0}}, w_status};

    always_comb begin
        w_rdata = '0;
        if (w_idx <= TGT_LAST) begin
            w_rdata = 32'(r_tgt[w_idx[CH_W-1:0]]);
        end else if (w_idx >= REG_CUR0 && w_idx <= CUR_LAST) begin
            w_rdata = 32'(r_cur[w_idx[CH_W-1:0]]);
        end else if (w_idx == REG_STEP) begin
            w_rdata = 32'(r_step);
        end else if (w_idx == REG_PRESCALE) begin
            w_rdata = 32'(r_presc);
        end else if (w_idx == REG_STATUS) begin
            w_rdata = w_status_word;
        end
    end

    // A single stepper is shared across channels; the sweep feeds it one channel per cycle.
    servo_ramp_step #(
        .DUTY_W (DUTY_W)
    ) u_step (
        .i_cur  (r_cur[r_ch]),
        .i_tgt  (r_tgt[r_ch]),
        .i_step (r_step),
        .o_next (w_next)
    );

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_snap[i*DUTY_W +: DUTY_W] = (CH_W'(i) == r_ch) ? w_next : r_cur[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_req ? w_rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step  <= '0;
            r_presc <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_tgt[i] <= '0;
            end
        end else if (w_wr) begin
            if (w_idx <= TGT_LAST) begin
                r_tgt[w_idx[CH_W-1:0]] <= wb_dat_i[DUTY_W-1:0];
            end
            if (w_idx == REG_STEP) begin
                r_step <= wb_dat_i[DUTY_W-1:0];
            end
            if (w_idx == REG_PRESCALE) begin
                r_presc <= wb_dat_i[PRESC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_wr && w_idx == REG_PRESCALE) || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The duty snapshot is taken on the edge into LOAD, substituting the last
    // channel's fresh step result, so duty_o and the strobe appear together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_duty  <= '0;
            r_load  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cur[i] <= '0;
            end
        end else begin
            r_load <= w_last;
            if (w_last) begin
                r_duty <= w_snap;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_SWEEP;
                        r_ch    <= '0;
                    end
                end
                ST_SWEEP: begin
                    r_cur[r_ch] <= w_next;
                    if (r_ch == LAST_CH) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef WB_SERVO_RAMP_IRQ_EN
    logic r_busy_pre;
    logic r_irq;

    // Remember whether any channel was still ramping when the sweep began.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_pre <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_tick) begin
                r_busy_pre <= |w_status;
            end
            if (r_state == ST_LOAD && r_busy_pre && !(|w_status)) begin
                r_irq <= 1'b1;
            end else if (w_wr && w_idx == REG_STATUS) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign w_irq = r_irq;
`else
    assign w_irq = 1'b0;
`endif

    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat;
    assign duty_o      = r_duty;
    assign duty_load_o = r_load;
    assign irq_o       = w_irq;

endmodule

// File: tb/tb_wb_servo_ramp.sv
// Self-checking bench for wb_servo_ramp: scoreboard queues hold expected read
// data and expected duty snapshots, popped when the DUT acks or strobes.
module tb_wb_servo_ramp;

    localparam int NUM_CH = 8;
    localparam int DUTY_W = 16;
`ifdef WB_SERVO_RAMP_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] IRQ_BIT = IRQ_ON ? 32'h8000_0000 : 32'h0;

    localparam logic [31:0] A_STEP   = 32'h7000_0020;
    localparam logic [31:0] A_PRESC  = 32'h7000_0024;
    localparam logic [31:0] A_STATUS = 32'h7000_0028;
    localparam logic [31:0] A_BASE   = 32'h7000_0000;
    localparam logic [31:0] A_CUR0   = 32'h7000_0040;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [31:0]              wb_adr_i;
    logic [31:0]              wb_dat_i;
    logic [31:0]              wb_dat_o;
    logic                     wb_we_i;
    logic                     wb_cyc_i;
    logic                     wb_stb_i;
    logic [3:0]               wb_sel_i;
    logic                     wb_ack_o;
    logic [NUM_CH*DUTY_W-1:0] duty_o;
    logic                     duty_load_o;
    logic                     irq_o;

    int numChecks = 0;
    int numFails  = 0;
    int cycleCount = 0;
    int loadCount = 0;
    int irqCount = 0;

    logic [31:0] expQ [$];
    logic [15:0] dutyQ [$];

    wb_servo_ramp dut (
        .clk         (clk),
        .rst         (rst),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_we_i     (wb_we_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_sel_i    (wb_sel_i),
        .wb_ack_o    (wb_ack_o),
        .duty_o      (duty_o),
        .duty_load_o (duty_load_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    always @(negedge clk) begin
        if (duty_load_o === 1'b1) loadCount <= loadCount + 1;
        if (irq_o === 1'b1) irqCount <= irqCount + 1;
    end

    task automatic wbWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] sel, output logic ok, output int at);
        @(negedge clk);
        wb_adr_i = addr;
        wb_dat_i = data;
        wb_sel_i = sel;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        ok = 1'b0;
        at = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o === 1'b1) begin
                ok = 1'b1;
                at = cycleCount;
                break;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wbRead(input logic [31:0] addr, output logic [31:0] data, output logic ok);
        @(negedge clk);
        wb_adr_i = addr;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        ok = 1'b0;
        data = 32'hDEAD_BEEF;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o === 1'b1) begin
                ok = 1'b1;
                data = wb_dat_o;
                break;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    task automatic waitLoad(input int maxCycles, output logic ok,
                            output logic [NUM_CH*DUTY_W-1:0] duty, output int at);
        ok = 1'b0;
        duty = '0;
        at = 0;
        for (int k = 0; k < maxCycles; k++) begin
            @(posedge clk);
            #1;
            if (duty_load_o === 1'b1) begin
                ok = 1'b1;
                duty = duty_o;
                at = cycleCount;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp;
        logic ok;
        int at;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        numChecks++;
        if (duty_o !== '0 || duty_load_o !== 1'b0 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || irq_o !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL reset_outputs: duty=%h load=%b ack=%b dat=%h irq=%b, expected all zero",
                     duty_o, duty_load_o, wb_ack_o, wb_dat_o, irq_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            expQ.push_back((i == 9) ? 32'h0000_FFFF : 32'h0);
            wbRead(A_BASE + 32'(i * 4), rd, ok);
            exp = expQ.pop_front();
            numChecks++;
            if (!ok || rd !== exp) begin
                numFails++;
                $display("[TB] FAIL reset_reg[%0d]: got %h (ack=%b) expected %h", i, rd, ok, exp);
            end
        end
        @(posedge clk);
        #1;
        numChecks++;
        if (wb_ack_o !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL ack_single_cycle: ack=%b expected 0", wb_ack_o);
        end
        wbWrite(A_BASE + 32'h4, 32'h0000_ABCD, 4'h3, ok, at);
        expQ.push_back(32'h0);
        wbRead(A_BASE + 32'h4, rd, ok);
        exp = expQ.pop_front();
        numChecks++;
        if (!ok || rd !== exp) begin
            numFails++;
            $display("[TB] FAIL partial_sel_write: got %h expected %h", rd, exp);
        end
        wbWrite(A_BASE + 32'h30, 32'h1234_5678, 4'hF, ok, at);
        expQ.push_back(32'h0);
        wbRead(A_BASE + 32'h30, rd, ok);
        exp = expQ.pop_front();
        numChecks++;
        if (!ok || rd !== exp) begin
            numFails++;
            $display("[TB] FAIL unmapped_write: got %h expected %h", rd, exp);
        end
        numChecks++;
        if (loadCount !== 0 || duty_o !== '0) begin
            numFails++;
            $display("[TB] FAIL no_load_after_reset: loads=%0d duty=%h expected 0 and 0", loadCount, duty_o);
        end
    endtask

    task automatic test_ramp();
        logic ok;
        logic [31:0] rd;
        logic [31:0] exp;
        logic [15:0] expDuty;
        logic [NUM_CH*DUTY_W-1:0] duty;
        int at;
        int prevAt;
        int expGap;
        wbWrite(A_STEP, 32'd100, 4'hF, ok, at);
        wbWrite(A_BASE + 32'hC, 32'd250, 4'hF, ok, at);
        wbWrite(A_PRESC, 32'd20, 4'hF, ok, prevAt);
        dutyQ.push_back(16'd100);
        dutyQ.push_back(16'd200);
        dutyQ.push_back(16'd250);
        for (int i = 0; i < 3; i++) begin
            expGap = (i == 0) ? (20 + NUM_CH + 1) : 21;
            waitLoad(60, ok, duty, at);
            expDuty = dutyQ.pop_front();
            numChecks++;
            if (!ok || duty[3*DUTY_W +: DUTY_W] !== expDuty) begin
                numFails++;
                $display("[TB] FAIL ramp_duty3[%0d]: got %h (strobe=%b) expected %h",
                         i, duty[3*DUTY_W +: DUTY_W], ok, expDuty);
            end
            numChecks++;
            if (at - prevAt !== expGap) begin
                numFails++;
                $display("[TB] FAIL ramp_timing[%0d]: got %0d cycles expected %0d", i, at - prevAt, expGap);
            end
            prevAt = at;
            @(posedge clk);
            #1;
            numChecks++;
            if (duty_load_o !== 1'b0) begin
                numFails++;
                $display("[TB] FAIL strobe_width[%0d]: load=%b expected 0", i, duty_load_o);
            end
            expQ.push_back((i == 2) ? IRQ_BIT : 32'h8);
            wbRead(A_STATUS, rd, ok);
            exp = expQ.pop_front();
            numChecks++;
            if (!ok || rd !== exp) begin
                numFails++;
                $display("[TB] FAIL ramp_status[%0d]: got %h expected %h", i, rd, exp);
            end
            if (i == 0) begin
                expQ.push_back(32'd100);
                wbRead(A_CUR0 + 32'hC, rd, ok);
                exp = expQ.pop_front();
                numChecks++;
                if (!ok || rd !== exp) begin
                    numFails++;
                    $display("[TB] FAIL cur3_read: got %h expected %h", rd, exp);
                end
            end
        end
    endtask

    task automatic test_irq();
        logic ok;
        logic [31:0] rd;
        logic [31:0] exp;
        int at;
        numChecks++;
        if (irq_o !== IRQ_ON) begin
            numFails++;
            $display("[TB] FAIL irq_set: irq=%b expected %b", irq_o, IRQ_ON);
        end
        expQ.push_back(IRQ_BIT);
        wbRead(A_STATUS, rd, ok);
        exp = expQ.pop_front();
        numChecks++;
        if (!ok || rd !== exp) begin
            numFails++;
            $display("[TB] FAIL irq_status: got %h expected %h", rd, exp);
        end
        wbWrite(A_STATUS, 32'h0, 4'hF, ok, at);
        numChecks++;
        if (irq_o !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL irq_clear: irq=%b expected 0", irq_o);
        end
        expQ.push_back(32'h0);
        wbRead(A_STATUS, rd, ok);
        exp = expQ.pop_front();
        numChecks++;
        if (!ok || rd !== exp) begin
            numFails++;
            $display("[TB] FAIL irq_status_cleared: got %h expected %h", rd, exp);
        end
    endtask

    task automatic test_saturate();
        logic ok;
        logic [15:0] expDuty;
        logic [NUM_CH*DUTY_W-1:0] duty;
        int at;
        waitLoad(60, ok, duty, at);
        numChecks++;
        if (!ok || duty[3*DUTY_W +: DUTY_W] !== 16'd250) begin
            numFails++;
            $display("[TB] FAIL ramp_hold: got %h expected %h", duty[3*DUTY_W +: DUTY_W], 16'd250);
        end
        wbWrite(A_STEP, 32'h0, 4'hF, ok, at);
        wbWrite(A_BASE, 32'h2000, 4'hF, ok, at);
        dutyQ.push_back(16'h2000);
        for (int i = 0; i < 4; i++) begin
            waitLoad(60, ok, duty, at);
            expDuty = dutyQ.pop_front();
            numChecks++;
            if (!ok || duty[DUTY_W-1:0] !== expDuty) begin
                numFails++;
                $display("[TB] FAIL saturate_duty0[%0d]: got %h expected %h", i, duty[DUTY_W-1:0], expDuty);
            end
            if (i == 0) begin
                wbWrite(A_STEP, 32'hF000, 4'hF, ok, at);
                wbWrite(A_BASE, 32'hFFFF, 4'hF, ok, at);
                dutyQ.push_back(16'hFFFF);
            end else if (i == 1) begin
                wbWrite(A_BASE, 32'h0, 4'hF, ok, at);
                dutyQ.push_back(16'h0FFF);
                dutyQ.push_back(16'h0000);
            end
        end
    endtask

    task automatic test_jump_prescale();
        logic ok;
        logic [15:0] expDuty;
        logic [NUM_CH*DUTY_W-1:0] duty;
        int at;
        int prevAt;
        wbWrite(A_STEP, 32'h0, 4'hF, ok, at);
        wbWrite(A_BASE + 32'h1C, 32'h1234, 4'hF, ok, at);
        dutyQ.push_back(16'h1234);
        waitLoad(60, ok, duty, at);
        expDuty = dutyQ.pop_front();
        numChecks++;
        if (!ok || duty[7*DUTY_W +: DUTY_W] !== expDuty) begin
            numFails++;
            $display("[TB] FAIL jump_duty7: got %h expected %h", duty[7*DUTY_W +: DUTY_W], expDuty);
        end
        wbWrite(A_PRESC, 32'd3, 4'hF, ok, prevAt);
        waitLoad(60, ok, duty, at);
        numChecks++;
        if (!ok || at - prevAt !== 16 + NUM_CH + 1) begin
            numFails++;
            $display("[TB] FAIL floor_latency: got %0d cycles expected %0d", at - prevAt, 16 + NUM_CH + 1);
        end
        prevAt = at;
        waitLoad(60, ok, duty, at);
        numChecks++;
        if (!ok || at - prevAt !== 17) begin
            numFails++;
            $display("[TB] FAIL floor_period: got %0d cycles expected %0d", at - prevAt, 17);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic [15:0] expDuty;
        logic [NUM_CH*DUTY_W-1:0] duty;
        int at;
        wbWrite(A_PRESC, 32'd20, 4'hF, ok, at);
        wbWrite(A_STEP, 32'h10, 4'hF, ok, at);
        wbWrite(A_BASE + 32'h8, 32'h100, 4'hF, ok, at);
        dutyQ.push_back(16'h0010);
        dutyQ.push_back(16'h0020);
        dutyQ.push_back(16'h0010);
        dutyQ.push_back(16'h0005);
        for (int i = 0; i < 4; i++) begin
            waitLoad(60, ok, duty, at);
            expDuty = dutyQ.pop_front();
            numChecks++;
            if (!ok || duty[2*DUTY_W +: DUTY_W] !== expDuty) begin
                numFails++;
                $display("[TB] FAIL midsweep_duty2[%0d]: got %h expected %h", i, duty[2*DUTY_W +: DUTY_W], expDuty);
            end
            if (i == 0) begin
                // Next tick lands 12 cycles after LOAD; channel 2 sweeps 3 cycles later.
                repeat (15) @(posedge clk);
                wbWrite(A_BASE + 32'h8, 32'h5, 4'hF, ok, at);
            end
        end
    endtask

    task automatic test_reset_midsweep();
        logic ok;
        logic [31:0] rd;
        logic [31:0] exp;
        int loadsBefore;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        numChecks++;
        if (duty_o !== '0 || duty_load_o !== 1'b0 || irq_o !== 1'b0 || wb_ack_o !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL midsweep_reset: duty=%h load=%b irq=%b ack=%b expected all zero",
                     duty_o, duty_load_o, irq_o, wb_ack_o);
        end
        loadsBefore = loadCount;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        numChecks++;
        if (loadCount !== loadsBefore) begin
            numFails++;
            $display("[TB] FAIL no_strobe_after_reset: got %0d loads expected %0d", loadCount, loadsBefore);
        end
        expQ.push_back(32'h0);
        expQ.push_back(32'h0000_FFFF);
        wbRead(A_CUR0 + 32'h8, rd, ok);
        exp = expQ.pop_front();
        numChecks++;
        if (!ok || rd !== exp) begin
            numFails++;
            $display("[TB] FAIL cur2_after_reset: got %h expected %h", rd, exp);
        end
        wbRead(A_PRESC, rd, ok);
        exp = expQ.pop_front();
        numChecks++;
        if (!ok || rd !== exp) begin
            numFails++;
            $display("[TB] FAIL prescale_after_reset: got %h expected %h", rd, exp);
        end
    endtask

    initial begin
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_sel_i = 4'h0;
        rst      = 1'b1;
        test_reset();
        test_ramp();
        test_irq();
        test_saturate();
        test_jump_prescale();
        test_back_to_back();
        test_reset_midsweep();
        numChecks++;
        if ((irqCount != 0) !== IRQ_ON) begin
            numFails++;
            $display("[TB] FAIL irq_activity: seen=%b expected %b", irqCount != 0, IRQ_ON);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb_servo_ramp.md
Name: wb_servo_ramp

Overview:
- Wishbone slave at 0x70000000 (conbus slot s_addr 3'b111).
- Sits directly upstream of the PWM generator. Firmware writes per-channel target duty values and a step size.
- Block ramps each channel's current duty toward its target once per prescaled tick.
- Drives the packed duty bus plus a one-cycle load strobe into the PWM generator, so motor speed changes are slew-limited in hardware.

Parameters:
- NUM_CH, 8, number of duty channels (fixed to 8 for the motor board).
- DUTY_W, 16, width of duty/target/step values.
- MIN_PRESCALE, 16, floor applied to the PRESCALE register so a full channel sweep always completes between ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wb_adr_i  in  32  byte address; word index = wb_adr_i[6:2].
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_sel_i  in  4  byte selects; only all-ones writes take effect, other writes are acked and ignored.
- wb_ack_o  out  1  acknowledge.
- duty_o  out  NUM_CH*DUTY_W  current duty, channel n at bits [n*DUTY_W +: DUTY_W].
- duty_load_o  out  1  one-cycle pulse: duty_o is new and consistent.
- irq_o  out  1  ramp-complete interrupt (see Optional Feature).

Behaviour:
- Register map (word index):
  - 0..7: TARGET[n], RW, low DUTY_W bits.
  - 8: STEP, RW.
  - 9: PRESCALE, RW.
  - 10: STATUS, RO. Bit n = 1 while CUR[n] != TARGET[n]. Bit 31 = irq pending; writing any value clears it.
  - 16..23: CUR[n], RO.
  - Unmapped indices read 0; writes to them are ignored.
- Wishbone handshake:
  - wb_ack_o asserts exactly one cycle after cyc&stb with ack low, and holds for one cycle.
  - The cycle after an ack is always ack-low, so every access takes 2 cycles.
  - Writes commit on the ack cycle. wb_dat_o is registered and valid on the ack cycle.
- Reset values:
  - All TARGET, all CUR, and STEP = 0.
  - PRESCALE = 0xFFFF.
  - wb_ack_o = 0, wb_dat_o = 0, duty_o = 0, duty_load_o = 0, irq_o = 0.
  - FSM in IDLE, prescaler counter = 0.
- Prescaler:
  - Free-running counter, runs in every FSM state.
  - Terminal value = max(PRESCALE, MIN_PRESCALE).
  - On reaching the terminal value it emits a 1-cycle tick and wraps to 0; tick period = terminal+1 clocks.
  - Writing PRESCALE resets the counter to 0.
- FSM, states IDLE, SWEEP, LOAD:
  - IDLE: on tick go to SWEEP with ch=0.
  - SWEEP: one channel per cycle. CUR[ch] <= step(CUR[ch], TARGET[ch], STEP). After ch=NUM_CH-1 go to LOAD.
  - LOAD: duty_o <= all CUR, duty_load_o=1 for this single cycle, then IDLE.
  - Tick-to-strobe latency: NUM_CH+1 cycles.
  - A tick arriving outside IDLE cannot occur, because MIN_PRESCALE > NUM_CH+2.
- Step arithmetic (performed in DUTY_W+1 bits, no wrap-around):
  - STEP==0: CUR=TARGET, i.e. an immediate jump.
  - CUR<TARGET: CUR=min(CUR+STEP, TARGET).
  - CUR>TARGET: CUR=max(CUR-STEP, TARGET), saturating at TARGET and never underflowing.
  - CUR==TARGET: unchanged.
- Simultaneous events:
  - A TARGET[n] write in the same cycle SWEEP processes channel n: the step uses the old TARGET and the new value is stored. The new target takes effect next tick.
  - A CUR read during SWEEP returns the register value at the ack cycle.
- duty_o changes only in LOAD, so the PWM generator never sees a partial sweep.
- Reset mid-sweep: all state returns to reset values asynchronously, with no strobe.

Optional Feature:
- Macro: WB_SERVO_RAMP_IRQ_EN.
- Defined:
  - A sticky pending bit is set in the LOAD cycle when STATUS[7:0] goes from nonzero before the sweep to zero after it.
  - irq_o = pending bit. A write to STATUS clears it; if clear and set coincide, set wins.
- Undefined:
  - irq_o tied to 0 and STATUS[31] reads 0.
  - No pending-bit logic is synthesized.

Decomposition:
- Package servo_ramp_pkg holds:
  - NUM_CH and DUTY_W defaults.
  - Register word-index constants REG_TARGET0=0, REG_STEP=8, REG_PRESCALE=9, REG_STATUS=10, REG_CUR0=16.
  - FSM state encoding: IDLE=2'd0, SWEEP=2'd1, LOAD=2'd2.
- One sub-module, servo_ramp_step: purely combinational saturating step (cur, tgt, step -> next). Instantiated once and muxed by ch.

Test Plan:
- Reset then read all registers -> TARGET/CUR/STEP = 0, PRESCALE = 0xFFFF, STATUS = 0, duty_o = 0, no duty_load_o pulse.
- PRESCALE=20, STEP=100, TARGET[3]=250:
  - CUR[3] goes 100, 200, 250 on successive ticks.
  - duty_load_o pulses every 21 clocks, NUM_CH+1 cycles after each tick.
  - STATUS bit3 clears after the third LOAD.
- TARGET[0]=0xFFFF, STEP=0xF000 from CUR=0x2000 -> next CUR=0xFFFF, saturated with no wrap. Then TARGET[0]=0, STEP=0xF000 -> CUR goes 0x0FFF, then 0.
- STEP=0, TARGET[7]=0x1234 -> CUR[7]=0x1234 after one tick. PRESCALE=3 written -> measured tick period is 17 clocks (MIN_PRESCALE floor).
- Write TARGET[2] in the exact SWEEP cycle for ch=2 -> that sweep uses the old target, next sweep uses the new one. Assert rst mid-SWEEP -> outputs 0 immediately, no duty_load_o.
- With WB_SERVO_RAMP_IRQ_EN: ramp completes -> irq_o=1 and STATUS[31]=1; STATUS write -> irq_o=0. Without the macro: irq_o stays 0 throughout.
